pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
Downstream PWM output stage for the swerve steering path. Accepts ratio update requests from the angle/PWM controller and double-buffers the ratio. Applies each new ratio only at a PWM period boundary, so no runt pulses reach the motor driver, then returns a one-cycle pwm_done acknowledge. Drives the single-ended PWM pin to the motor driver.

Parameters:
PRESCALE, 4, main-clock cycles per PWM tick; legal range 1..256.
RAMP_STEP, 8, maximum ratio change per PWM period. Used only when PWM_SOFT_START_EN is defined; legal range 1..255.

Ports:
clock  input  1  main clock
reset_n  input  1  reset; asynchronous, active-low
pwm_enable  input  1  level; 1 = generate PWM, 0 = output forced low
pwm_update  input  1  one-cycle request to load pwm_ratio
pwm_ratio  input  8  requested high-time out of 255 ticks
pwm_done  output  1  one-cycle pulse: requested ratio now active
pwm_out  output  1  PWM signal to motor driver
period_start  output  1  one-cycle pulse at each period boundary
active_ratio  output  8  ratio currently driving pwm_out

Behaviour:
- Reset values: pwm_done=0, pwm_out=0, period_start=0, active_ratio=0, pending=0, pending_valid=0, prescaler=0, period_cnt=0, state=DISABLED.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick=1 when prescaler==PRESCALE-1. With PRESCALE=1, tick=1 every cycle.
- period_cnt: 8-bit, advances on tick through 0..254, then wraps to 0. One period = 255 ticks = 255*PRESCALE clocks.
- Boundary: the tick on which period_cnt==254. period_start is registered and pulses in the cycle after the boundary, aligned with period_cnt==0.
- pwm_out: registered; pwm_out = (period_cnt < active_ratio).
  - ratio 0 -> constant low.
  - ratio 255 -> constant high.
- Update capture: when pwm_update=1, pending<=pwm_ratio and pending_valid<=1.
  - Repeated updates before a boundary: last value wins; only one pwm_done is issued.
- States:
  - DISABLED:
    - prescaler and period_cnt held at 0; pwm_out=0.
    - If pending_valid: active_ratio<=pending, pending_valid<=0, pwm_done pulses next cycle. The controller is never stalled.
    - pwm_enable=1 -> RUN; the first period starts at period_cnt=0.
  - RUN:
    - On a boundary with pending_valid: active_ratio<=pending, pending_valid<=0. pwm_done and period_start pulse together in the next cycle.
    - pwm_update in the same cycle as the boundary tick: the incoming pwm_ratio is applied directly at that boundary (bypass), not deferred a period.
    - pwm_enable=0 -> DISABLED next cycle; pwm_out low next cycle; counters cleared.
- pwm_done: never asserted for two consecutive cycles; never asserted without a preceding pwm_update.
- Reset mid-period: all state is cleared immediately; pwm_out drops asynchronously to 0.

Optional Feature:
Macro: PWM_SOFT_START_EN
- Defined:
  - At each boundary while target (pending) differs from active_ratio, active_ratio moves toward the target by min(RAMP_STEP, |diff|). Arithmetic is 9-bit and saturates at 0 and 255.
  - pending_valid clears and pwm_done pulses only at the boundary where active_ratio reaches the target.
  - A new pwm_update mid-ramp retargets the ramp from the current active_ratio.
  - In DISABLED, the ramp is skipped; active_ratio loads the target directly.
- Not defined: each ratio is applied in a single step, as described under Behaviour.

Test Plan:
- Reset with pwm_enable=1 and no update -> pwm_out=0 permanently; period_start every 1020 clocks (PRESCALE=4); pwm_done never asserted.
- Update to 64, then steady state -> pwm_done one cycle after the next boundary; pwm_out high exactly 256 clocks of each 1020.
- Ratio 0 -> pwm_out never high; ratio 255 -> pwm_out constantly high across the boundary, with no low glitch.
- Updates 10, 100, 200 within one period -> a single pwm_done; active_ratio=200 after the boundary.
- pwm_update=1 with ratio 128 on the boundary tick -> active_ratio=128 in the next period; pwm_out high 512 clocks.
- pwm_enable=0 and update to 50 -> pwm_done one cycle later, pwm_out stays 0. Re-enable -> 200 high clocks per period starting at period_cnt=0.
- (PWM_SOFT_START_EN, RAMP_STEP=8) Update 0->30 -> active_ratio 8, 16, 24, 30 over four boundaries; pwm_done only at 30.

Source files
------------

// File: rtl/pwm_gen.sv
// Double-buffered PWM output stage: ratio updates take effect only at a period boundary.
// Optional `PWM_SOFT_START_EN: ratio ramps toward the target by at most RAMP_STEP per period.
module pwm_gen #(
  parameter int PRESCALE  = 4,
  parameter int RAMP_STEP = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] active_ratio
);

  localparam logic [0:0] ST_DISABLED = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  // Reject parameter values outside the legal range at elaboration.
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("pwm_gen: PRESCALE out of range");
  end
  if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_ramp
    $error("pwm_gen: RAMP_STEP out of range");
  end

`ifdef PWM_SOFT_START_EN
  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  // One ramp step from cur toward tgt, limited to RAMP_STEP and saturated to 0..255.
  function automatic logic [7:0] ramp_next(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] diff;
    logic [8:0] step;
    logic [8:0] sum;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      step = (diff > STEP9) ? STEP9 : diff;
      sum  = {1'b0, cur} + step;
      ramp_next = (sum > 9'd255) ? 8'd255 : sum[7:0];
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      step = (diff > STEP9) ? STEP9 : diff;
      sum  = {1'b0, cur} - step;
      ramp_next = sum[8] ? 8'd0 : sum[7:0];
    end
  endfunction
`endif

  logic [0:0]    state_r;
  logic [PW-1:0] prescaler_r;
  logic [7:0]    period_cnt_r;
  logic [7:0]    pending_r;
  logic          pending_valid_r;

  logic [0:0]    state_s;
  logic [PW-1:0] prescaler_s;
  logic [7:0]    period_cnt_s;
  logic [7:0]    pending_s;
  logic          pending_valid_s;
  logic [7:0]    active_s;
  logic          done_s;
  logic          start_s;
  logic          out_s;
  logic          tick_s;
  logic          boundary_s;
  logic [7:0]    target_s;
  logic          target_valid_s;
`ifdef PWM_SOFT_START_EN
  logic [7:0]    ramp_s;
`endif

  // Tick, boundary and the effective target (an update on the boundary bypasses the buffer).
  always_comb begin
    tick_s         = (prescaler_r == PRE_LAST);
    boundary_s     = tick_s && (period_cnt_r == 8'd254);
    target_s       = pwm_update ? pwm_ratio : pending_r;
    target_valid_s = pwm_update || pending_valid_r;
  end

  // Next-state logic for counters, ratio buffer and output pulses.
  always_comb begin
    state_s         = state_r;
    prescaler_s     = prescaler_r;
    period_cnt_s    = period_cnt_r;
    active_s        = active_ratio;
    done_s          = 1'b0;
    start_s         = 1'b0;
    out_s           = 1'b0;
`ifdef PWM_SOFT_START_EN
    ramp_s          = ramp_next(active_ratio, target_s);
`endif
    if (pwm_update) begin
      pending_s       = pwm_ratio;
      pending_valid_s = 1'b1;
    end else begin
      pending_s       = pending_r;
      pending_valid_s = pending_valid_r;
    end

    case (state_r)
      ST_DISABLED: begin
        prescaler_s  = {PW{1'b0}};
        period_cnt_s = 8'd0;
        // A fresh update defers the load by one cycle so pwm_done can never pulse back-to-back.
        if (pending_valid_r && !pwm_update) begin
          active_s        = pending_r;
          pending_valid_s = 1'b0;
          done_s          = 1'b1;
        end else begin
          active_s = active_ratio;
        end
        if (pwm_enable) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DISABLED;
        end
      end

      ST_RUN: begin
        if (!pwm_enable) begin
          state_s      = ST_DISABLED;
          prescaler_s  = {PW{1'b0}};
          period_cnt_s = 8'd0;
          out_s        = 1'b0;
        end else begin
          state_s     = ST_RUN;
          prescaler_s = tick_s ? {PW{1'b0}} : (prescaler_r + PW'(1));
          if (!tick_s) begin
            period_cnt_s = period_cnt_r;
          end else if (period_cnt_r == 8'd254) begin
            period_cnt_s = 8'd0;
          end else begin
            period_cnt_s = period_cnt_r + 8'd1;
          end
          out_s   = (period_cnt_r < active_ratio);
          start_s = boundary_s;
          if (boundary_s && target_valid_s) begin
`ifdef PWM_SOFT_START_EN
            active_s = ramp_s;
            if (ramp_s == target_s) begin
              pending_valid_s = 1'b0;
              done_s          = 1'b1;
            end else begin
              pending_valid_s = 1'b1;
              done_s          = 1'b0;
            end
`else
            active_s        = target_s;
            pending_valid_s = 1'b0;
            done_s          = 1'b1;
`endif
          end else begin
            active_s = active_ratio;
          end
        end
      end

      default: begin
        state_s         = ST_DISABLED;
        prescaler_s     = {PW{1'b0}};
        period_cnt_s    = 8'd0;
        pending_s       = 8'd0;
        pending_valid_s = 1'b0;
        active_s        = 8'd0;
      end
    endcase
  end

  // State and output registers; reset clears pwm_out immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_DISABLED;
      prescaler_r     <= {PW{1'b0}};
      period_cnt_r    <= 8'd0;
      pending_r       <= 8'd0;
      pending_valid_r <= 1'b0;
      active_ratio    <= 8'd0;
      pwm_done        <= 1'b0;
      period_start    <= 1'b0;
      pwm_out         <= 1'b0;
    end else begin
      state_r         <= state_s;
      prescaler_r     <= prescaler_s;
      period_cnt_r    <= period_cnt_s;
      pending_r       <= pending_s;
      pending_valid_r <= pending_valid_s;
      active_ratio    <= active_s;
      pwm_done        <= done_s;
      period_start    <= start_s;
      pwm_out         <= out_s;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen (PRESCALE=4, one period = 1020 clocks).
module tb_pwm_gen;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pwm_enable;
  logic       pwm_update;
  logic [7:0] pwm_ratio;
  logic       pwm_done;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] active_ratio;

  int n_checks = 0;
  int n_fails  = 0;
  int len_v, high_v, done_v;
  logic prev_done = 1'b0;
  logic consec_done = 1'b0;

  pwm_gen #(.PRESCALE(4), .RAMP_STEP(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pwm_enable   (pwm_enable),
    .pwm_update   (pwm_update),
    .pwm_ratio    (pwm_ratio),
    .pwm_done     (pwm_done),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .active_ratio (active_ratio)
  );

  always #5 clock = ~clock;

  // Flag any back-to-back pwm_done pulses.
  always @(negedge clock) begin
    if (pwm_done && prev_done) consec_done = 1'b1;
    prev_done = pwm_done;
  end

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 3000);
    if (n >= 3000) check_eq("period_start_timeout", 32'd0, 32'd1);
  endtask

  // Count pwm_out/pwm_done from the current cycle up to (excluding) the next period_start.
  task automatic measure(output int len, output int high, output int dones);
    len = 0; high = 0; dones = 0;
    forever begin
      if (pwm_out === 1'b1) high++;
      if (pwm_done === 1'b1) dones++;
      step();
      len++;
      if (period_start === 1'b1) break;
      if (len >= 3000) begin
        check_eq("measure_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] r);
    pwm_update = 1'b1;
    pwm_ratio  = r;
    step();
    pwm_update = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pwm_enable = 1'b1; pwm_update = 1'b0; pwm_ratio = 8'd0;
    step(); step();
    check_eq("rst_done", pwm_done, 1'b0);
    check_eq("rst_out", pwm_out, 1'b0);
    check_eq("rst_start", period_start, 1'b0);
    check_eq("rst_active", active_ratio, 8'd0);
    reset_n = 1'b1;

`ifdef PWM_SOFT_START_EN
    wait_start();
    send(8'd30);
    wait_start();
    check_eq("ramp1_active", active_ratio, 8'd8);
    check_eq("ramp1_done", pwm_done, 1'b0);
    wait_start();
    check_eq("ramp2_active", active_ratio, 8'd16);
    check_eq("ramp2_done", pwm_done, 1'b0);
    wait_start();
    check_eq("ramp3_active", active_ratio, 8'd24);
    check_eq("ramp3_done", pwm_done, 1'b0);
    wait_start();
    check_eq("ramp4_active", active_ratio, 8'd30);
    check_eq("ramp4_done", pwm_done, 1'b1);
    measure(len_v, high_v, done_v);
    check_eq("ramp_high", high_v, 32'd120);
`else
    // Enabled with no update: output stays low, period is 1020 clocks.
    wait_start();
    measure(len_v, high_v, done_v);
    check_eq("idle_len", len_v, 32'd1020);
    check_eq("idle_high", high_v, 32'd0);
    check_eq("idle_done", done_v, 32'd0);

    // Ratio 64 applied at the next boundary.
    send(8'd64);
    check_eq("r64_deferred", active_ratio, 8'd0);
    wait_start();
    check_eq("r64_done", pwm_done, 1'b1);
    check_eq("r64_active", active_ratio, 8'd64);
    measure(len_v, high_v, done_v);
    check_eq("r64_high", high_v, 32'd256);
    check_eq("r64_len", len_v, 32'd1020);
    measure(len_v, high_v, done_v);
    check_eq("r64_high_steady", high_v, 32'd256);
    check_eq("r64_no_done", done_v, 32'd0);

    // Ratio 0 and ratio 255 extremes.
    send(8'd0);
    wait_start();
    check_eq("r0_active", active_ratio, 8'd0);
    measure(len_v, high_v, done_v);
    check_eq("r0_high", high_v, 32'd0);
    send(8'd255);
    wait_start();
    check_eq("r255_active", active_ratio, 8'd255);
    measure(len_v, high_v, done_v);
    check_eq("r255_high_first", high_v, 32'd1019);
    measure(len_v, high_v, done_v);
    check_eq("r255_high_steady", high_v, 32'd1020);

    // Three updates in one period: last wins, one pwm_done.
    step(); step();
    send(8'd10);
    send(8'd100);
    step();
    send(8'd200);
    check_eq("multi_deferred", active_ratio, 8'd255);
    wait_start();
    check_eq("multi_active", active_ratio, 8'd200);
    measure(len_v, high_v, done_v);
    check_eq("multi_done_cnt", done_v, 32'd1);
    check_eq("multi_high", high_v, 32'd801);

    // Update exactly on the boundary tick is applied at that boundary.
    repeat (1019) step();
    check_eq("bypass_pre_start", period_start, 1'b0);
    send(8'd128);
    check_eq("bypass_start", period_start, 1'b1);
    check_eq("bypass_done", pwm_done, 1'b1);
    check_eq("bypass_active", active_ratio, 8'd128);
    measure(len_v, high_v, done_v);
    check_eq("bypass_high", high_v, 32'd512);

    // Disable plus update: loads without waiting, output stays low.
    step(); step(); step();
    pwm_enable = 1'b0;
    send(8'd50);
    check_eq("dis_out_low", pwm_out, 1'b0);
    begin
      int n;
      n = 0;
      while (pwm_done !== 1'b1 && n < 4) begin
        step();
        n++;
      end
      check_eq("dis_done_seen", pwm_done, 1'b1);
    end
    check_eq("dis_active", active_ratio, 8'd50);
    begin
      int hi;
      hi = 0;
      repeat (40) begin
        step();
        if (pwm_out !== 1'b0) hi++;
      end
      check_eq("dis_out_quiet", hi, 32'd0);
    end

    // Re-enable: first period starts at count 0, 200 high clocks.
    pwm_enable = 1'b1;
    measure(len_v, high_v, done_v);
    check_eq("reen_len", len_v, 32'd1021);
    check_eq("reen_high", high_v, 32'd200);
    measure(len_v, high_v, done_v);
    check_eq("reen_high_steady", high_v, 32'd200);

    // Asynchronous reset while pwm_out is high.
    step(); step();
    check_eq("pre_rst_out", pwm_out, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_out", pwm_out, 1'b0);
    check_eq("async_rst_active", active_ratio, 8'd0);
    step();
    reset_n = 1'b1;
`endif

    check_eq("done_never_consecutive", consec_done, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
